// File: rtl/adder9_rr_scheduler_if.sv
// Handshake bundle between the operand requesters and the shared 9-bit adder scheduler.
// ADDER9_SCHED_PARITY_EN adds the rsp_par response bit.
interface adder9_rr_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [9*NREQ-1:0] req_a;
  logic [9*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [9:0]        rsp_sum;
  logic [ID_W-1:0]   rsp_id;
  logic              busy;
`ifdef ADDER9_SCHED_PARITY_EN
  logic              rsp_par;
`endif

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id, busy
`ifdef ADDER9_SCHED_PARITY_EN
    , input rsp_par
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
`ifdef ADDER9_SCHED_PARITY_EN
    , output rsp_par
`endif
  );
endinterface

// File: rtl/adder9_rr_scheduler.sv
// Round-robin scheduler sharing one 9b+9b ripple-carry adder among NREQ requesters.
// Optional ADDER9_SCHED_PARITY_EN registers an even-parity bit of the result.
module adder9_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  adder9_rr_scheduler_if.slave  bus
);
  localparam int unsigned OP_W  = 9;
  localparam int unsigned SUM_W = 10;
  localparam int unsigned IW1   = ID_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [SUM_W-1:0]  rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              busy_q, busy_d;
`ifdef ADDER9_SCHED_PARITY_EN
  logic              rsp_par_q, rsp_par_d;
`endif

  logic              found;
  logic [ID_W-1:0]   gnt_idx;
  logic [IW1-1:0]    idx;
  logic [NREQ-1:0]   grant;
  logic [OP_W-1:0]   sel_a, sel_b;
  logic [SUM_W-1:0]  sum_c;

  function automatic logic [SUM_W-1:0] adder9bit(input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b);
    logic            c;
    logic [OP_W-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 9; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  // First valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW1'(ptr_q) + IW1'(k);
      if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == IDLE && found) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a = bus.req_a[OP_W*i +: OP_W];
        sel_b = bus.req_b[OP_W*i +: OP_W];
      end
    end
  end

  assign sum_c = adder9bit(op_a_q, op_b_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
`ifdef ADDER9_SCHED_PARITY_EN
    rsp_par_d   = rsp_par_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          gid_d   = gnt_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_sum_d   = sum_c;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
`ifdef ADDER9_SCHED_PARITY_EN
        rsp_par_d   = ^sum_c;
`endif
        ptr_d       = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + ID_W'(1);
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
`ifdef ADDER9_SCHED_PARITY_EN
      rsp_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
`ifdef ADDER9_SCHED_PARITY_EN
      rsp_par_q   <= rsp_par_d;
`endif
    end
  end

  // Grant is combinational so a requester sees acceptance in the same IDLE cycle
  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy_q;
`ifdef ADDER9_SCHED_PARITY_EN
  assign bus.rsp_par   = rsp_par_q;
`endif
endmodule

// File: tb/tb_adder9_rr_scheduler.sv
// Scoreboard bench for adder9_rr_scheduler: directed operations push expected responses,
// a monitor pops and checks each response as the DUT presents it.
module tb_adder9_rr_scheduler;
  typedef struct packed {
    logic [1:0] id;
    logic [9:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  adder9_rr_scheduler_if #(.NREQ(4), .ID_W(2)) bus ();

  adder9_rr_scheduler #(.NREQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [8:0] a, input logic [8:0] b);
    bus.req_a[9*i +: 9] = a;
    bus.req_b[9*i +: 9] = b;
  endtask

  task automatic push(input int id, input logic [9:0] sum);
    exp_t e;
    e.id  = 2'(id);
    e.sum = sum;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); #1;
      ok = !bus.busy && !bus.rsp_valid;
    end
    chk("wait_idle", 16'(ok), 16'd1);
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); #1;
      ok = bus.rsp_valid;
    end
    chk("wait_valid", 16'(ok), 16'd1);
  endtask

  task automatic do_single(input int id, input logic [8:0] a, input logic [8:0] b,
                           input logic [9:0] sum);
    @(negedge clk);
    set_op(id, a, b);
    bus.req_valid = 4'(1 << id);
    bus.rsp_ready = 1'b1;
    push(id, sum);
    #1 chk("single_grant", 16'(bus.req_ready), 16'(1 << id));
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("calc_busy", 16'(bus.busy), 16'd1);
    chk("calc_no_grant", 16'(bus.req_ready), 16'd0);
    wait_idle();
  endtask

  // Response monitor: a new response is one that appears after none or after an accept
  initial begin : monitor
    bit   pending = 1'b0;
    bit   acc;
    exp_t hold;
    exp_t e;
    hold = '0;
    forever begin
      @(posedge clk);
      acc = bus.rsp_valid && bus.rsp_ready;
      #1;
      if (bus.rsp_valid) begin
        if (!pending || acc) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h expected no response at %0t",
                     bus.rsp_id, bus.rsp_sum, $time);
          end else begin
            e    = sb.pop_front();
            hold = e;
            chk("rsp_id", 16'(bus.rsp_id), 16'(e.id));
            chk("rsp_sum", 16'(bus.rsp_sum), 16'(e.sum));
`ifdef ADDER9_SCHED_PARITY_EN
            chk("rsp_par", 16'(bus.rsp_par), 16'(^e.sum));
`endif
          end
        end else begin
          chk("stall_id", 16'(bus.rsp_id), 16'(hold.id));
          chk("stall_sum", 16'(bus.rsp_sum), 16'(hold.sum));
        end
        pending = 1'b1;
      end else begin
        pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_rsp_sum", 16'(bus.rsp_sum), 16'd0);
    chk("rst_rsp_id", 16'(bus.rsp_id), 16'd0);
    chk("rst_req_ready", 16'(bus.req_ready), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single op and carry cases; ptr advances 0 -> 1 -> 2 -> 3
    do_single(0, 9'h0FF, 9'h001, 10'h100);
    do_single(1, 9'h1FF, 9'h1FF, 10'h3FE);
    do_single(2, 9'h000, 9'h000, 10'h000);

    // Reset while a response is held; ptr would otherwise point at 3
    @(negedge clk);
    set_op(2, 9'h155, 9'h0AA);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    push(2, 10'h1FF);
    #1 chk("pre_rst_grant", 16'(bus.req_ready), 16'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    wait_valid();
    @(negedge clk);
    rst = 1'b1;
    set_op(0, 9'h001, 9'h002);
    set_op(1, 9'h010, 9'h020);
    set_op(2, 9'h100, 9'h0FF);
    set_op(3, 9'h1F0, 9'h01F);
    bus.req_valid = 4'b1111;
    #1;
    chk("midrsp_rst_valid", 16'(bus.rsp_valid), 16'd0);
    chk("midrsp_rst_busy", 16'(bus.busy), 16'd0);
    chk("midrsp_rst_sum", 16'(bus.rsp_sum), 16'd0);
    chk("midrsp_rst_grant", 16'(bus.req_ready), 16'b0001);
    push(0, 10'h003);
    push(1, 10'h030);
    push(2, 10'h1FF);
    push(3, 10'h20F);
    push(0, 10'h003);
    @(negedge clk);
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;

    // All four requesting: grants 0,1,2,3,0 spaced three cycles apart
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", 16'(bus.req_ready), 16'(1 << (k % 4)));
      if (k < 4) begin
        repeat (3) @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle();

    // Backpressure with req3 waiting behind req1 (ptr=1)
    @(negedge clk);
    set_op(1, 9'h0AB, 9'h155);
    set_op(3, 9'h0F0, 9'h00F);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b0;
    push(1, 10'h200);
    push(3, 10'h0FF);
    #1 chk("bp_grant", 16'(bus.req_ready), 16'b0010);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_no_grant", 16'(bus.req_ready), 16'd0);
      chk("bp_valid_held", 16'(bus.rsp_valid), 16'd1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_next_grant", 16'(bus.req_ready), 16'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle();

    // Fairness: after req2 is granted, req3 beats req1 (ptr=3)
    @(negedge clk);
    set_op(2, 9'h123, 9'h045);
    bus.req_valid = 4'b0100;
    push(2, 10'h168);
    push(3, 10'h100);
    push(1, 10'h200);
    #1 chk("fair_grant2", 16'(bus.req_ready), 16'b0100);
    @(negedge clk);
    set_op(1, 9'h1FF, 9'h001);
    set_op(3, 9'h080, 9'h080);
    bus.req_valid = 4'b1010;
    #1 chk("fair_calc_ready", 16'(bus.req_ready), 16'd0);
    @(negedge clk); #1;
    chk("fair_resp_ready", 16'(bus.req_ready), 16'd0);
    @(negedge clk); #1;
    chk("fair_grant3", 16'(bus.req_ready), 16'b1000);
    @(negedge clk);
    bus.req_valid = 4'b0010;
    repeat (2) @(negedge clk);
    #1 chk("fair_grant1", 16'(bus.req_ready), 16'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle();

    repeat (2) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
